// File: rtl/shared_mem_arbiter.sv
// N-core arbiter that serialises load/store requests onto one shared memory port,
// with round-robin or fixed-priority selection, range/alignment rejection and per-core grant counters.
module shared_mem_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int MEM_SIZE   = 1024,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  prio_mode,
   input  logic [NUM_CORES-1:0]                  req_valid,
   input  logic [NUM_CORES-1:0]                  req_we,
   input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_CORES-1:0][DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_CORES-1:0]                  resp_valid,
   output logic                                  resp_err,
   output logic [DATA_WIDTH-1:0]                 resp_rdata,
   output logic                                  mem_req,
   output logic                                  mem_we,
   output logic [ADDR_WIDTH-1:0]                 mem_addr,
   output logic [DATA_WIDTH-1:0]                 mem_wdata,
   input  logic                                  mem_ready,
   input  logic                                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0]                 mem_rdata,
   output logic                                  busy,
   output logic [NUM_CORES-1:0][CNT_WIDTH-1:0]   grant_count
);

   localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int BYTES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [IDX_W-1:0]        rr_ptr_reg, winner_reg, sel_idx, win_next;
   logic                    mode_reg, err_reg, err_next;
   logic                    sel_found, sel_bad;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic                    mem_req_next, busy_next, resp_err_next;
   logic [NUM_CORES-1:0]    resp_valid_next;
   logic [DATA_WIDTH-1:0]   resp_rdata_next;

   // Candidate search: rotated from rr_ptr in round-robin mode, from index 0 in fixed mode.
   always_comb begin
      int idx;
      idx       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         idx = prio_mode ? i : (int'(rr_ptr_reg) + i) % NUM_CORES;
         if (!sel_found && req_valid[idx]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(idx);
         end
      end
   end

   assign sel_addr = req_addr[sel_idx];
   assign sel_bad  = (sel_addr >= ADDR_WIDTH'(MEM_SIZE)) ||
                     ((sel_addr & ADDR_WIDTH'(BYTES - 1)) != '0);

   // State register plus latched transaction fields and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         winner_reg <= '0;
         mode_reg   <= 1'b0;
         err_reg    <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_valid <= '0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         busy       <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mem_req    <= mem_req_next;
         busy       <= busy_next;
         resp_valid <= resp_valid_next;
         resp_err   <= resp_err_next;
         resp_rdata <= resp_rdata_next;
         if (state_reg == IDLE && sel_found) begin
            winner_reg <= sel_idx;
            mode_reg   <= prio_mode;
            err_reg    <= sel_bad;
            mem_we     <= req_we[sel_idx];
            mem_addr   <= sel_addr;
            mem_wdata  <= req_wdata[sel_idx];
         end
         if (state_reg == DONE && !mode_reg)
            rr_ptr_reg <= (int'(winner_reg) == NUM_CORES - 1) ? '0 : winner_reg + 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (sel_found) state_next = sel_bad ? DONE : ISSUE;
         ISSUE:   if (mem_ready) state_next = mem_we ? DONE : WAIT_RD;
         WAIT_RD: if (mem_rvalid) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in the state they belong to.
   always_comb begin
      win_next        = (state_reg == IDLE) ? sel_idx : winner_reg;
      err_next        = (state_reg == IDLE) ? sel_bad : err_reg;
      mem_req_next    = (state_next == ISSUE);
      busy_next       = (state_next != IDLE);
      resp_valid_next = '0;
      if (state_next == DONE)
         resp_valid_next[win_next] = 1'b1;
      resp_err_next   = (state_next == DONE) && err_next;
      resp_rdata_next = (state_reg == WAIT_RD && mem_rvalid) ? mem_rdata : '0;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CORES; gi++) begin : g_cnt
         logic [CNT_WIDTH-1:0] cnt_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               cnt_reg <= '0;
            else if (state_reg == DONE && !err_reg && winner_reg == IDX_W'(gi))
               cnt_reg <= cnt_reg + 1'b1;
         end
         assign grant_count[gi] = cnt_reg;
      end
   endgenerate

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised N-core arbiter that serialises per-core load/store requests onto one shared data-memory port inside the multicore top. It supports round-robin or fixed-priority selection, range and alignment checking with an error response, and per-core grant counters for the bench's memory-access monitor. One transaction is outstanding at a time.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores (≥2)
- ADDR_WIDTH, 64, byte-address width
- DATA_WIDTH, 64, data width; must be a power-of-two number of bytes
- MEM_SIZE, 1024, shared memory size in bytes; legal addresses are 0..MEM_SIZE-1
- CNT_WIDTH, 32, grant counter width

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only in IDLE
- req_valid  in  [NUM_CORES]  per-core request
- req_we  in  [NUM_CORES]  1 = write
- req_addr  in  [NUM_CORES][ADDR_WIDTH]  byte address
- req_wdata  in  [NUM_CORES][DATA_WIDTH]  write data
- resp_valid  out  [NUM_CORES]  one-cycle completion pulse to the winning core
- resp_err  out  1  qualifies resp_valid; 1 = rejected, no memory access performed
- resp_rdata  out  DATA_WIDTH  read data; valid with resp_valid
- mem_req  out  1  request to the shared memory
- mem_we, mem_addr, mem_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  from the latched winner
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data
- busy  out  1  state ≠ IDLE
- grant_count  out  [NUM_CORES][CNT_WIDTH]  completed (non-error) transactions per core; wraps

## Operation
- State machine: IDLE → ISSUE → (WAIT_RD) → DONE → IDLE.
- IDLE:
  - If any req_valid is high, pick a winner and latch its index, we, addr and wdata.
  - Round-robin: search starts at rr_ptr and wraps modulo NUM_CORES.
  - Fixed priority: lowest set index wins.
  - If the latched address is out of range (addr ≥ MEM_SIZE) or misaligned (low log2(DATA_WIDTH/8) bits ≠ 0), set err and go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Drive mem_req=1 with the latched fields; hold them until mem_ready.
  - On mem_ready: a write goes to DONE, a read goes to WAIT_RD.
- WAIT_RD: on mem_rvalid, latch mem_rdata and go to DONE. There is no timeout.
- DONE:
  - Pulse resp_valid[winner] for one cycle.
  - Drive resp_err = err and resp_rdata = latched data (0 for writes and errors).
  - If err=0, increment grant_count[winner].
  - In round-robin mode, set rr_ptr = (winner+1) mod NUM_CORES, including on error. rr_ptr is unchanged in fixed mode.
  - Return to IDLE.
- Core rules:
  - A core holds req_* stable from assertion until it sees resp_valid, then drops req_valid in the next cycle.
  - A core whose req_valid drops before it is granted is simply not selected.
  - Changing req_* while a request is pending is undefined.
- Only the latched winner's fields reach the mem_* outputs; other cores' inputs are ignored until the next IDLE.
- A mem_rvalid arriving outside WAIT_RD is ignored.
- mem_ready arriving outside ISSUE is ignored.

## Timing
- Reset (asynchronous, immediate): state=IDLE, rr_ptr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0, resp_rdata=0, busy=0, all grant_count=0.
- A reset asserted mid-transaction aborts it: mem_req drops asynchronously and no response is issued.
- Request in IDLE at cycle 0 gives:
  - ISSUE at cycle 1.
  - Write with mem_ready=1 immediately: resp_valid at cycle 2 (3-cycle latency).
  - Read with mem_ready at cycle 1 and mem_rvalid at cycle 2: resp_valid at cycle 3.
  - Error: resp_valid at cycle 1 with resp_err=1; mem_req never asserts.
- Each mem_ready stall cycle or rvalid delay cycle adds one cycle to the latency.
- Back-to-back: minimum arbitration spacing is one IDLE cycle, so one write completes at most every 3 cycles.
- mem_* outputs, resp_* outputs and busy are all registered.
- grant_count updates on the edge that ends DONE and is visible the cycle after resp_valid.

## Test plan
- Single write: core 2 writes 0xDEADBEEF to 0x10, mem_ready tied 1. Required: mem_req for 1 cycle with addr 0x10 and we=1; resp_valid=4'b0100 at cycle 2; resp_err=0; grant_count[2]=1.
- Read with stalls: core 1 reads 0x8; mem_ready is delayed 2 cycles, then mem_rvalid arrives 3 cycles later with 0x1234. Required: mem_addr held stable while stalled; resp_rdata=0x1234 with resp_valid[1] at cycle 7.
- Round-robin fairness: all 4 cores request continuously (each re-asserting after its response), prio_mode=0. Required: grant order 0,1,2,3,0,1…; after 8 grants each grant_count=2.
- Fixed priority: the same traffic with prio_mode=1. Required: only core 0 is granted while it keeps requesting; cores 1–3 have grant_count=0.
- Errors:
  - Core 3 reads 0x400 (= MEM_SIZE). Required: resp_err=1 at cycle 1, mem_req never high, grant_count[3] unchanged.
  - Core 0 reads 0x4 (misaligned). Required: same error behaviour.
- Reset mid-read: rst_n is pulled low while in WAIT_RD. Required: mem_req=0 and busy=0 immediately; no resp_valid; all counters 0. After release, a new request completes normally.
